// File: rtl/pflink_pkg.sv
// Shared pflink constants and encodings: K-characters, lock FSM states, spy modes.
package pflink_pkg;

  localparam logic [7:0] COMMA_K = 8'hBC;
  localparam logic [7:0] PAD_K   = 8'h1C;
  localparam logic [7:0] IDLE_K  = 8'h3C;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  typedef enum logic [1:0] {
    SPY_FREE  = 2'd0,
    SPY_COMMA = 2'd1,
    SPY_ERR   = 2'd2,
    SPY_OFF   = 2'd3
  } spy_mode_e;

  typedef enum logic [1:0] {
    SPY_IDLE = 2'd0,
    SPY_WAIT = 2'd1,
    SPY_CAP  = 2'd2
  } spy_state_e;

endpackage

// File: rtl/pflink_rx_assembler_if.sv
// Receive lane bus: decoded GTX halfwords in, assembled frames out.
interface pflink_rx_assembler_if #(
  parameter int WORDS_OUT = 2
);
  logic [15:0]             rx_d;
  logic [1:0]              rx_k;
  logic [1:0]              rx_nit;
  logic                    rx_rstdone;
  logic [16*WORDS_OUT-1:0] out_d;
  logic [2*WORDS_OUT-1:0]  out_k;
  logic                    out_v;
  logic                    out_ok;

  modport master (
    output rx_d, rx_k, rx_nit, rx_rstdone,
    input  out_d, out_k, out_v, out_ok
  );

  modport slave (
    input  rx_d, rx_k, rx_nit, rx_rstdone,
    output out_d, out_k, out_v, out_ok
  );
endinterface

// File: rtl/pflink_spy_ram.sv
// Simple dual-port spy capture memory: one write port, one registered read port.
module pflink_spy_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk_link,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_link) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_link) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/pflink_rx_assembler.sv
// pflink receive word assembler: comma alignment, frame build, lock FSM,
// saturating status counters and a triggerable spy capture buffer.
module pflink_rx_assembler
  import pflink_pkg::*;
#(
  parameter int         WORDS_OUT   = 2,
  parameter logic [7:0] COMMA       = COMMA_K,
  parameter logic [7:0] PAD         = PAD_K,
  parameter int         LOCK_COMMAS = 4,
  parameter int         UNLOCK_ERRS = 8,
  parameter int         SPY_AW      = 6,
  parameter int         CNT_W       = 32
) (
  input  logic                  clk_link,
  input  logic                  reset,
  pflink_rx_assembler_if.slave  lnk,
  output logic                  locked,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      comma_cnt,
  output logic [CNT_W-1:0]      unlock_cnt,
  input  logic [1:0]            spy_mode,
  input  logic                  spy_arm,
  input  logic [SPY_AW-1:0]     spy_raddr,
  output logic [31:0]           spy_rdata,
  output logic                  spy_done
);

  localparam int PH_W = (WORDS_OUT > 1) ? $clog2(WORDS_OUT) : 1;
  localparam int FW   = 16 * WORDS_OUT;
  localparam int KW   = 2 * WORDS_OUT;
  localparam int LC_W = $clog2(LOCK_COMMAS + 1);
  localparam int UE_W = $clog2(UNLOCK_ERRS + 1);
  localparam logic [PH_W-1:0] LAST  = PH_W'(WORDS_OUT - 1);
  localparam logic [3:0]      SPACE = 4'(WORDS_OUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  // Stage p0: classify the incoming halfword
  logic            err_hw_p0, comma_p0, short_p0, hw_err_p0, bad_k_p0, last_p0;
  logic [PH_W-1:0] phase, slot_p0;

  always_comb begin
    err_hw_p0 = (|lnk.rx_nit) | ~lnk.rx_rstdone |
                (lnk.rx_k[1] & (lnk.rx_d[15:8] == COMMA));
    comma_p0  = (lnk.rx_k == 2'b01) & (lnk.rx_d[7:0] == COMMA);
    short_p0  = comma_p0 & (phase != '0);
    hw_err_p0 = err_hw_p0 | short_p0;
    slot_p0   = comma_p0 ? '0 : phase;
    last_p0   = (slot_p0 == LAST);
    bad_k_p0  = ~((lnk.rx_k == 2'b00) | (lnk.rx_k == 2'b11) | comma_p0);
  end

  logic [FW-1:0] acc_d, frame_d;
  logic [KW-1:0] acc_k, frame_k;
  logic          acc_err, acc_bad, frame_err, frame_bad;

  // Slot 0 restarts the flags, so a discarded short frame leaves nothing behind
  always_comb begin
    frame_d = acc_d;
    frame_k = acc_k;
    frame_d[int'(slot_p0)*16 +: 16] = lnk.rx_d;
    frame_k[int'(slot_p0)*2 +: 2]   = lnk.rx_k;
    frame_err = err_hw_p0 | ((slot_p0 != '0) & acc_err);
    frame_bad = bad_k_p0  | ((slot_p0 != '0) & acc_bad);
  end

  always_ff @(posedge clk_link) begin
    acc_d <= frame_d;
    acc_k <= frame_k;
  end

  lock_state_e lock_state, lock_next;

  // Stage p1: registered frame output
  always_ff @(posedge clk_link) begin
    if (reset) begin
      phase      <= '0;
      acc_err    <= 1'b0;
      acc_bad    <= 1'b0;
      lnk.out_v  <= 1'b0;
      lnk.out_ok <= 1'b0;
      lnk.out_d  <= '0;
      lnk.out_k  <= '0;
    end else begin
      phase     <= last_p0 ? '0 : slot_p0 + 1'b1;
      acc_err   <= frame_err;
      acc_bad   <= frame_bad;
      lnk.out_v <= last_p0;
      if (last_p0) begin
        lnk.out_d  <= frame_bad ? {KW{PAD}} : frame_d;
        lnk.out_k  <= frame_bad ? '1 : frame_k;
        lnk.out_ok <= ~frame_bad & ~frame_err & (lock_state == LOCKED);
      end
    end
  end

  logic [LC_W-1:0] comma_run, comma_run_next;
  logic [UE_W-1:0] err_run, err_run_next;
  logic [3:0]      since, since_next;
  logic            unlock_ev;

  // First comma of a run needs no predecessor; later ones must land exactly WORDS_OUT apart
  always_comb begin
    lock_next      = lock_state;
    comma_run_next = comma_run;
    err_run_next   = err_run;
    unlock_ev      = 1'b0;
    since_next     = comma_p0 ? 4'd1 : ((since == 4'hF) ? since : since + 4'd1);
    case (lock_state)
      HUNT: begin
        err_run_next = '0;
        if (hw_err_p0) begin
          comma_run_next = '0;
        end else if (comma_p0) begin
          if ((comma_run == '0) || (since == SPACE)) begin
            if (comma_run == LC_W'(LOCK_COMMAS - 1)) begin
              lock_next      = LOCKED;
              comma_run_next = '0;
            end else begin
              comma_run_next = comma_run + 1'b1;
            end
          end else begin
            comma_run_next = '0;
          end
        end else if (since >= SPACE) begin
          comma_run_next = '0;
        end
      end
      LOCKED: begin
        comma_run_next = '0;
        if (hw_err_p0) begin
          if (err_run == UE_W'(UNLOCK_ERRS - 1)) begin
            lock_next    = HUNT;
            err_run_next = '0;
            unlock_ev    = 1'b1;
          end else begin
            err_run_next = err_run + 1'b1;
          end
        end else begin
          err_run_next = '0;
        end
      end
      default: lock_next = HUNT;
    endcase
  end

  always_ff @(posedge clk_link) begin
    if (reset) begin
      lock_state <= HUNT;
      comma_run  <= '0;
      err_run    <= '0;
      since      <= '0;
      err_cnt    <= '0;
      comma_cnt  <= '0;
      unlock_cnt <= '0;
    end else begin
      lock_state <= lock_next;
      comma_run  <= comma_run_next;
      err_run    <= err_run_next;
      since      <= since_next;
      err_cnt    <= sat_inc(err_cnt, hw_err_p0, cnt_clear);
      comma_cnt  <= sat_inc(comma_cnt, comma_p0, cnt_clear);
      unlock_cnt <= sat_inc(unlock_cnt, unlock_ev, cnt_clear);
    end
  end

  assign locked = (lock_state == LOCKED);

  spy_state_e      spy_state, spy_state_next;
  spy_mode_e       spy_mode_q;
  logic [SPY_AW-1:0] spy_ptr, spy_ptr_next;
  logic            spy_done_next, spy_we, spy_trig;
  logic [31:0]     spy_wdata;

  // The trigger word itself is written at entry 0, then one entry per cycle until wrap
  always_comb begin
    spy_state_next = spy_state;
    spy_ptr_next   = spy_ptr;
    spy_done_next  = spy_done;
    spy_we         = 1'b0;
    spy_trig       = (spy_mode_q == SPY_COMMA) ? comma_p0 : hw_err_p0;
    spy_wdata      = {12'h000, lnk.rx_nit, lnk.rx_k, lnk.rx_d};
    if (spy_arm) begin
      spy_ptr_next  = '0;
      spy_done_next = 1'b0;
      case (spy_mode_e'(spy_mode))
        SPY_FREE: spy_state_next = SPY_CAP;
        SPY_OFF:  spy_state_next = SPY_IDLE;
        default:  spy_state_next = SPY_WAIT;
      endcase
    end else begin
      case (spy_state)
        SPY_WAIT, SPY_CAP: begin
          if ((spy_state == SPY_CAP) || spy_trig) begin
            spy_we         = 1'b1;
            spy_ptr_next   = spy_ptr + 1'b1;
            spy_state_next = SPY_CAP;
            if (spy_ptr == '1) begin
              spy_done_next  = 1'b1;
              spy_state_next = SPY_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_link) begin
    if (reset) begin
      spy_state  <= SPY_IDLE;
      spy_ptr    <= '0;
      spy_done   <= 1'b0;
      spy_mode_q <= SPY_OFF;
    end else begin
      spy_state <= spy_state_next;
      spy_ptr   <= spy_ptr_next;
      spy_done  <= spy_done_next;
      if (spy_arm) spy_mode_q <= spy_mode_e'(spy_mode);
    end
  end

  pflink_spy_ram #(
    .AW (SPY_AW),
    .DW (32)
  ) u_spy_ram (
    .clk_link (clk_link),
    .reset    (reset),
    .we       (spy_we),
    .waddr    (spy_ptr),
    .wdata    (spy_wdata),
    .raddr    (spy_raddr),
    .rdata    (spy_rdata)
  );

endmodule
